cordic_post_stage: RTL and testbench
====================================

// Module: cordic_post_stage
// PURPOSE
//  Output stage directly after the last CORDIC iteration stage of the dual-vector pipeline.
//  Takes the final x/y of vector A (a/b) and vector P (p/q), plus the accumulated angle.
//  Removes the CORDIC gain (x 1/1.64676) and applies a coarse quadrant offset to the angle.
//  The free-running pipeline cannot stall, so results go into a small FWFT FIFO; the
//  consumer drains it through a valid/ready handshake.
// PARAMETERS
//  N      31     MSB index of data words; data width is N+1, signed
//  DEPTH  4      FIFO entries; power of two, >= 2
//  K_Q15  19898  gain-compensation constant, unsigned Q1.15 (0.60725)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous reset, active-high
//  in_valid   in   1      final iteration stage outputs valid this cycle
//  ax         in   N+1    final x of vector A, signed
//  px         in   N+1    final x of vector P, signed
//  qy         in   N+1    final y of vector P, signed
//  outangle   in   16     accumulated angle, binary angle units (BAU, 2^16 = 360 deg)
//  quad       in   2      quadrant tag carried alongside the pipeline
//  out_valid  out  1      FIFO head valid (FIFO not empty)
//  out_ready  in   1      consumer accepts head this cycle
//  mag_a      out  N+1    gain-compensated ax
//  rot_p      out  N+1    gain-compensated px
//  rot_q      out  N+1    gain-compensated qy
//  angle_out  out  16     quadrant-corrected angle
//  level      out  clog2(DEPTH)+1  FIFO occupancy
//  overflow   out  1      sticky: a result was dropped
// BEHAVIOUR
//  Reset values (async, all state): pipeline valids = 0; FIFO pointers and level = 0;
//  out_valid = 0; overflow = 0. FIFO data is don't-care, and outputs show X-free zeros.
//  Reset mid-operation discards all in-flight and queued results immediately.
//  S1, cycle 1, on in_valid:
//   - register ax*K_Q15, px*K_Q15 and qy*K_Q15 as signed products of width N+17;
//   - register angle_s1 = outangle + {quad,14'b0}, mod 2^16 (wraps, no flag).
//  S2, cycle 2, for each product:
//   - res = (prod + 2^14) >>> 15, arithmetic shift: round half-up toward +inf;
//   - truncate res to N+1 bits (always fits because |K| < 1, no saturation);
//   - register the three results with the angle.
//  Push: the S2 valid writes to the FIFO at the next edge. Minimum in-to-out_valid latency = 3 clk.
//  Valids move every cycle, with no stall. Back-to-back in_valid is supported at 1 result/clk.
//  FIFO: first-word-fall-through. mag_a/rot_p/rot_q/angle_out always show the head entry.
//   - pop when out_valid & out_ready;
//   - push and pop together when full: both happen, level is unchanged, no drop;
//   - push when full and no pop: the new result is dropped, FIFO is unchanged, overflow
//     sets and holds until rst;
//   - pop when empty: ignored;
//   - pointers wrap mod DEPTH; level runs 0..DEPTH.
//  out_valid is combinational from level != 0. No combinational path from out_ready to out_valid.
// CONFIGURATION
//  CORDIC_GAIN_COMP_EN defined: behaviour as above.
//  Not defined:
//   - S1 registers ax/px/qy sign-extended to N+17 and shifted left 15;
//   - S2 rounding then returns the input value unchanged;
//   - latency, FIFO and angle handling are identical, and no multipliers are inferred.
// TESTING
//  T1 rst held, then released:
//   - out_valid=0, level=0, overflow=0;
//   - in_valid pulsed with ax=100000 -> 3 clk later out_valid=1, mag_a=60724 (bypass: 100000).
//  T2 ax=-100000, px=32768, qy=0:
//   - mag_a=-60724, rot_p=19898, rot_q=0 (rounding/sign check).
//  T3 angle wrap:
//   - outangle=0x3000, quad=2 -> angle_out=0xB000;
//   - outangle=0x5000, quad=3 -> angle_out=0x1000.
//  T4 out_ready=0 with 6 back-to-back inputs, DEPTH=4:
//   - level saturates at 4 and overflow=1;
//   - draining yields inputs 1-4 in order, then out_valid=0.
//  T5 FIFO full, out_ready=1 during a continuous input stream:
//   - level stays 4, no drop, overflow stays 0, output order preserved.
//  T6 rst asserted while 2 results are in S1/S2 and 3 are queued:
//   - out_valid=0 and level=0 immediately, with no late pushes after release.

Source files
------------

// File: rtl/cordic_post_stage.sv
// CORDIC output stage: removes the CORDIC gain from the three final x/y words, applies
// the quadrant offset to the angle, and buffers results in a FWFT FIFO.
// Build option: define CORDIC_GAIN_COMP_EN to enable the gain multipliers (otherwise bypass).

module cordic_post_lane #(
  parameter int N = 31
`ifdef CORDIC_GAIN_COMP_EN
  , parameter int K_Q15 = 19898
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s1_en,
  input  logic              s2_en,
  input  logic signed [N:0] din,
  output logic signed [N:0] dout
);
  logic signed [N+16:0] s1_nxt, prod, rnd;

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [N+16:0] K_EXT = (N+17)'(K_Q15);
  assign s1_nxt = (N+17)'(din) * K_EXT;
`else
  // Scale by 2^15 so the shared rounding step returns din unchanged.
  assign s1_nxt = {din[N], din, 15'b0};
`endif

  // Add half an LSB, then arithmetic shift: round half-up toward +inf.
  assign rnd = prod + (N+17)'(16384);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod <= '0;
      dout <= '0;
    end else begin
      if (s1_en) prod <= s1_nxt;
      if (s2_en) dout <= (N+1)'(rnd >>> 15);
    end
  end
endmodule

module cordic_post_stage #(
  parameter int N     = 31,
  parameter int DEPTH = 4,
  parameter int K_Q15 = 19898
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic signed [N:0]          ax,
  input  logic signed [N:0]          px,
  input  logic signed [N:0]          qy,
  input  logic [15:0]                outangle,
  input  logic [1:0]                 quad,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [N:0]          mag_a,
  output logic signed [N:0]          rot_p,
  output logic signed [N:0]          rot_q,
  output logic [15:0]                angle_out,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
);
  localparam int AW        = $clog2(DEPTH);
  localparam int NUM_LANES = 3;
  localparam int STAGES    = 2;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || K_Q15 < 1 || K_Q15 > 32767) begin : g_param_chk
    $error("cordic_post_stage: DEPTH must be a power of two >= 2 and K_Q15 in 1..32767");
  end

  typedef struct packed {
    logic signed [N:0] mag_a;
    logic signed [N:0] rot_p;
    logic signed [N:0] rot_q;
    logic [15:0]       angle;
  } entry_t;

  logic [STAGES-1:0]              vld_pipe;
  logic [15:0]                    angle_s1, angle_s2;
  logic [NUM_LANES-1:0][N:0]      lane_in, lane_out;

  // Lane 0 = ax, lane 1 = px, lane 2 = qy.
  assign lane_in = {qy, px, ax};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    cordic_post_lane #(
      .N(N)
`ifdef CORDIC_GAIN_COMP_EN
      , .K_Q15(K_Q15)
`endif
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .s1_en (in_valid),
      .s2_en (vld_pipe[0]),
      .din   (lane_in[g]),
      .dout  (lane_out[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      angle_s1 <= '0;
      angle_s2 <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-2:0], in_valid};
      if (in_valid)    angle_s1 <= outangle + {quad, 14'b0};
      if (vld_pipe[0]) angle_s2 <= angle_s1;
    end
  end

  entry_t         mem [DEPTH];
  entry_t         wr_ent;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic           push_req, push, pop, full;

  assign wr_ent   = '{mag_a: lane_out[0], rot_p: lane_out[1], rot_q: lane_out[2], angle: angle_s2};
  assign push_req = vld_pipe[STAGES-1];
  assign full     = (level == (AW+1)'(DEPTH));
  assign pop      = out_valid & out_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push     = push_req & (~full | pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_ent;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
      if (push_req && full && !pop) overflow <= 1'b1;
    end
  end

  assign out_valid = (level != '0);
  assign mag_a     = mem[rd_ptr].mag_a;
  assign rot_p     = mem[rd_ptr].rot_p;
  assign rot_q     = mem[rd_ptr].rot_q;
  assign angle_out = mem[rd_ptr].angle;
endmodule

// File: tb/tb_cordic_post_stage.sv
// Directed bench for cordic_post_stage: latency, rounding, angle wrap, FIFO full/overflow, reset.
module tb_cordic_post_stage;
  localparam int N     = 31;
  localparam int DEPTH = 4;

`ifdef CORDIC_GAIN_COMP_EN
  localparam int EXP_T1  = 60724;
  localparam int EXP_T2A = -60724;
  localparam int EXP_T2P = 19898;
`else
  localparam int EXP_T1  = 100000;
  localparam int EXP_T2A = -100000;
  localparam int EXP_T2P = 32768;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic signed [N:0] ax = '0, px = '0, qy = '0;
  logic [15:0]       outangle = '0;
  logic [1:0]        quad = '0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic signed [N:0] mag_a, rot_p, rot_q;
  logic [15:0]       angle_out;
  logic [2:0]        level;
  logic              overflow;

  int n_vec  = 0;
  int n_miss = 0;
  int exp_seq [12];
  int rd;

  cordic_post_stage #(.N(N), .DEPTH(DEPTH), .K_Q15(19898)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .ax(ax), .px(px), .qy(qy),
    .outangle(outangle), .quad(quad), .out_valid(out_valid), .out_ready(out_ready),
    .mag_a(mag_a), .rot_p(rot_p), .rot_q(rot_q), .angle_out(angle_out),
    .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] g(input int x);
`ifdef CORDIC_GAIN_COMP_EN
    longint p;
    p = longint'(x) * 19898 + 16384;
    return 32'(p >>> 15);
`else
    return x;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int a, input int p, input int q, input logic [15:0] ang, input logic [1:0] qd);
    in_valid = 1'b1;
    ax = a; px = p; qy = q; outangle = ang; quad = qd;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf",   overflow, 0);
    chk("rst_mag",   mag_a, 0);
    rst = 1'b0;
    tick();

    // T1: latency and basic gain
    send(100000, 0, 0, 16'h0000, 2'd0);
    tick();
    chk("t1_lat2", out_valid, 0);
    tick();
    chk("t1_valid", out_valid, 1);
    chk("t1_mag",   mag_a, EXP_T1);
    chk("t1_level", level, 1);
    pop1();
    chk("t1_empty", out_valid, 0);

    // T2: negative rounding and exact product
    send(-100000, 32768, 0, 16'h0000, 2'd0);
    tick(); tick();
    chk("t2_mag", mag_a, EXP_T2A);
    chk("t2_rp",  rot_p, EXP_T2P);
    chk("t2_rq",  rot_q, 0);
    pop1();

    // T3: angle wrap, back-to-back inputs
    send(0, 0, 0, 16'h3000, 2'd2);
    send(0, 0, 0, 16'h5000, 2'd3);
    tick(); tick();
    chk("t3_lvl",  level, 2);
    chk("t3_ang0", angle_out, 16'hB000);
    pop1();
    chk("t3_ang1", angle_out, 16'h1000);
    pop1();
    chk("t3_empty", out_valid, 0);

    // T4: overflow with no consumer
    for (int i = 1; i <= 6; i++) send(i * 1000, -i, i, 16'h0000, 2'd0);
    tick(); tick();
    chk("t4_lvl", level, 4);
    chk("t4_ovf", overflow, 1);
    for (int i = 1; i <= 4; i++) begin
      chk("t4_vld", out_valid, 1);
      chk("t4_ord", mag_a, g(i * 1000));
      pop1();
    end
    chk("t4_empty", out_valid, 0);
    chk("t4_lvl0",  level, 0);

    rst = 1'b1; tick(); rst = 1'b0; tick();
    chk("rst2_ovf", overflow, 0);

    // T5: full FIFO with simultaneous push/pop
    for (int i = 0; i < 12; i++) exp_seq[i] = 5000 + i * 777;
    for (int i = 0; i < 4; i++) send(exp_seq[i], 0, 0, 16'h0000, 2'd0);
    tick(); tick();
    chk("t5_full", level, 4);
    rd = 0;
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        in_valid = 1'b1;
        ax = exp_seq[4 + c];
      end else begin
        in_valid = 1'b0;
      end
      if (c >= 2) out_ready = 1'b1;
      if (out_valid && out_ready) begin
        chk("t5_ord", mag_a, g(exp_seq[rd]));
        rd++;
      end
      tick();
      chk("t5_lvl", level, 4);
    end
    in_valid = 1'b0;
    chk("t5_ovf", overflow, 0);
    for (int k = 0; k < 8; k++) begin
      if (!out_valid) break;
      chk("t5_drain", mag_a, g(exp_seq[rd]));
      rd++;
      tick();
    end
    out_ready = 1'b0;
    chk("t5_empty", out_valid, 0);
    chk("t5_count", rd, 12);

    // T6: reset with results in flight and queued
    for (int i = 0; i < 5; i++) send(700 + i, 0, 0, 16'h0000, 2'd0);
    chk("t6_pre", level, 3);
    rst = 1'b1;
    #1;
    chk("t6_vld", out_valid, 0);
    chk("t6_lvl", level, 0);
    tick(); tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("t6_late_lvl", level, 0);
    chk("t6_late_vld", out_valid, 0);
    chk("t6_late_ovf", overflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
